execute_alu_issue: RTL and testbench
====================================

// Module: execute_alu_issue
// PURPOSE
//  ALU issue queue and scheduler. Holds dispatched ALU uops until both source operands are ready.
//  Wakes waiting operands from the writeback broadcast and issues the oldest ready uop,
//  at most one per cycle, into execute_alu.
//  Sits between dispatch/rename and execute_alu; its issue outputs drive execute_alu i_* directly.
// PARAMETERS
//  DEPTH   4   number of queue entries (2..8); entry 0 is always the oldest
// PORTS
//  clk               in   1   clock, all state updates on rising edge
//  reset             in   1   synchronous, active-high reset
//  i_dsp_valid       in   1   dispatch request
//  o_dsp_ready       out  1   queue can accept a dispatch this cycle
//  i_dsp_src0_rdy    in   1   src0 value already valid at dispatch
//  i_dsp_src0_rob    in   4   ROB tag producing src0 (used when not ready)
//  i_dsp_src0_value  in   32  src0 value (used when ready)
//  i_dsp_src1_rdy    in   1   as src0, for src1
//  i_dsp_src1_rob    in   4   as src0, for src1
//  i_dsp_src1_value  in   32  as src0, for src1
//  i_dsp_dst_rob     in   4   destination ROB entry
//  i_dsp_imm         in   26  immediate field
//  i_dsp_fid         in   8   fetch id
//  i_dsp_alu_cmd     in   5   ALU command
//  i_wb_valid        in   1   writeback broadcast valid
//  i_wb_rob          in   4   writeback ROB tag
//  i_wb_value        in   32  writeback value
//  i_flush           in   1   pipeline flush; discard all entries
//  i_iss_ready       in   1   ALU port may take an issue this cycle (0 = port borrowed/stalled)
//  o_iss_valid       out  1   issue valid -> execute_alu i_valid
//  o_iss_src0_value  out  32  -> i_src0_value
//  o_iss_src1_value  out  32  -> i_src1_value
//  o_iss_dst_rob     out  4   -> i_dst_rob
//  o_iss_imm         out  26  -> i_imm
//  o_iss_fid         out  8   -> i_fid
//  o_iss_alu_cmd     out  5   -> i_alu_cmd
//  o_count           out  4   number of occupied entries
// BEHAVIOUR
//  - Reset: all entries invalid; o_count=0.
//    While reset is high: o_dsp_ready=0, o_iss_valid=0, all o_iss_* data=0.
//  - Entry state: valid, per-source rdy/rob/value, dst_rob, imm, fid, alu_cmd.
//  - Queue is compacting: entries occupy indices 0..count-1 in age order.
//  - Ready vector: rdy[k] = valid[k] & src0_rdy[k] & src1_rdy[k].
//  - Select: lowest index k with rdy[k]=1.
//    o_iss_valid = |rdy & i_iss_ready & ~i_flush & ~reset, combinational from entry regs.
//    o_iss_* data = fields of the selected entry; all zero when o_iss_valid=0.
//  - Issue fire (o_iss_valid=1): entry k is removed at the edge and entries k+1..count-1 shift down by one.
//  - o_dsp_ready = (count < DEPTH) & ~reset.
//    Registered count only; a same-cycle issue does not free a slot for a same-cycle dispatch.
//  - Dispatch fire (i_dsp_valid & o_dsp_ready & ~i_flush): new entry written at index count - (issue fire ? 1 : 0).
//  - Count update: count + dsp_fire - iss_fire; simultaneous dispatch and issue leaves count unchanged.
//  - Wakeup: on i_wb_valid, every valid entry source with rdy=0 and rob==i_wb_rob sets rdy=1 and captures i_wb_value.
//    Sources with rdy=1 are never overwritten. Both sources of one entry may wake in the same cycle.
//  - Dispatch bypass: if a dispatched source is not ready and i_wb_valid & i_wb_rob==that tag in the same cycle,
//    the source is stored ready with i_wb_value.
//  - Wakeup applies to the post-shift position of each entry (state moves with compaction).
//  - Latency: dispatch with both sources ready -> issuable the next cycle (1 cycle min).
//    Wakeup at edge t -> issuable in cycle t+1.
//  - Stall: i_iss_ready=0 blocks issue only; dispatch and wakeup continue, and ordering is kept.
//  - Flush: at the edge, all entries invalid and count=0.
//    Flush has priority over dispatch, issue and wakeup in the same cycle.
//  - i_dsp_valid while o_dsp_ready=0 is ignored; the upstream stage must hold the request.
// TESTING
//  1. Reset, dispatch {src0 rdy=5, src1 rdy=7, dst_rob=3}
//     -> next cycle o_iss_valid=1, src0=5, src1=7, dst_rob=3; o_count returns to 0.
//  2. Dispatch A (src0 waits on rob 9), then B (both ready)
//     -> B issues first; wb rob=9 value 0x1234 -> A issues next cycle with src0=0x1234.
//  3. Fill DEPTH=4 entries, none ready -> o_dsp_ready=0, o_count=4; dispatch ignored.
//     Wake all four -> issues in order 0,1,2,3 on consecutive cycles.
//  4. Dispatch with src1 waiting on rob 6 and wb rob=6 value 0xAA in the same cycle
//     -> issue next cycle with src1=0xAA.
//  5. i_iss_ready=0 for 3 cycles with 2 ready entries -> no issue, count=2;
//     release -> oldest issues first.
//  6. i_flush together with dispatch, issue and wakeup -> o_iss_valid=0 that cycle, o_count=0 after;
//     reset mid-operation -> same empty state, o_dsp_ready=0 during reset.

Source files
------------

// File: rtl/execute_alu_issue_if.sv
// Dispatch, writeback, flush and issue signal bundle for the ALU issue queue.
// The master side drives dispatch/wakeup/flush/stall, and the slave (queue) drives issue.
interface execute_alu_issue_if;
  logic        i_dsp_valid;
  logic        o_dsp_ready;
  logic        i_dsp_src0_rdy;
  logic [3:0]  i_dsp_src0_rob;
  logic [31:0] i_dsp_src0_value;
  logic        i_dsp_src1_rdy;
  logic [3:0]  i_dsp_src1_rob;
  logic [31:0] i_dsp_src1_value;
  logic [3:0]  i_dsp_dst_rob;
  logic [25:0] i_dsp_imm;
  logic [7:0]  i_dsp_fid;
  logic [4:0]  i_dsp_alu_cmd;
  logic        i_wb_valid;
  logic [3:0]  i_wb_rob;
  logic [31:0] i_wb_value;
  logic        i_flush;
  logic        i_iss_ready;
  logic        o_iss_valid;
  logic [31:0] o_iss_src0_value;
  logic [31:0] o_iss_src1_value;
  logic [3:0]  o_iss_dst_rob;
  logic [25:0] o_iss_imm;
  logic [7:0]  o_iss_fid;
  logic [4:0]  o_iss_alu_cmd;
  logic [3:0]  o_count;

  modport master (
    output i_dsp_valid, i_dsp_src0_rdy, i_dsp_src0_rob, i_dsp_src0_value,
    output i_dsp_src1_rdy, i_dsp_src1_rob, i_dsp_src1_value,
    output i_dsp_dst_rob, i_dsp_imm, i_dsp_fid, i_dsp_alu_cmd,
    output i_wb_valid, i_wb_rob, i_wb_value, i_flush, i_iss_ready,
    input  o_dsp_ready, o_iss_valid, o_iss_src0_value, o_iss_src1_value,
    input  o_iss_dst_rob, o_iss_imm, o_iss_fid, o_iss_alu_cmd, o_count
  );

  modport slave (
    input  i_dsp_valid, i_dsp_src0_rdy, i_dsp_src0_rob, i_dsp_src0_value,
    input  i_dsp_src1_rdy, i_dsp_src1_rob, i_dsp_src1_value,
    input  i_dsp_dst_rob, i_dsp_imm, i_dsp_fid, i_dsp_alu_cmd,
    input  i_wb_valid, i_wb_rob, i_wb_value, i_flush, i_iss_ready,
    output o_dsp_ready, o_iss_valid, o_iss_src0_value, o_iss_src1_value,
    output o_iss_dst_rob, o_iss_imm, o_iss_fid, o_iss_alu_cmd, o_count
  );
endinterface

// File: rtl/execute_alu_issue.sv
// Compacting ALU issue queue: holds uops until both sources are ready, wakes them from the
// writeback broadcast and issues the oldest ready entry, at most one per cycle.
module execute_alu_issue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  execute_alu_issue_if.slave bus
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DepthCnt = 4'(DEPTH);

  typedef struct packed {
    logic        valid;
    logic        s0_rdy;
    logic [3:0]  s0_rob;
    logic [31:0] s0_val;
    logic        s1_rdy;
    logic [3:0]  s1_rob;
    logic [31:0] s1_val;
    logic [3:0]  dst_rob;
    logic [25:0] imm;
    logic [7:0]  fid;
    logic [4:0]  alu_cmd;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  entry_t [DEPTH:0]   ent_ext;
  logic   [3:0]       count_q, count_d;
  logic   [DEPTH-1:0] rdy;
  logic               any_rdy;
  logic   [IdxW-1:0]  sel;
  entry_t             sel_ent;
  entry_t             new_ent;
  logic               iss_fire;
  logic               dsp_ready;
  logic               dsp_fire;
  logic   [3:0]       widx;

  // Oldest-ready select: the first ready index wins since entry 0 is the oldest.
  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    rdy     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rdy[k] = ent_q[k].valid & ent_q[k].s0_rdy & ent_q[k].s1_rdy;
      if (rdy[k] && !any_rdy) begin
        any_rdy = 1'b1;
        sel     = IdxW'(k);
      end
    end
  end

  assign sel_ent   = ent_q[sel];
  assign iss_fire  = any_rdy & bus.i_iss_ready & ~bus.i_flush & ~reset;
  assign dsp_ready = (count_q < DepthCnt) & ~reset;
  assign dsp_fire  = bus.i_dsp_valid & dsp_ready & ~bus.i_flush;
  assign widx      = count_q - 4'(iss_fire);

  assign bus.o_dsp_ready      = dsp_ready;
  assign bus.o_iss_valid      = iss_fire;
  assign bus.o_iss_src0_value = iss_fire ? sel_ent.s0_val  : '0;
  assign bus.o_iss_src1_value = iss_fire ? sel_ent.s1_val  : '0;
  assign bus.o_iss_dst_rob    = iss_fire ? sel_ent.dst_rob : '0;
  assign bus.o_iss_imm        = iss_fire ? sel_ent.imm     : '0;
  assign bus.o_iss_fid        = iss_fire ? sel_ent.fid     : '0;
  assign bus.o_iss_alu_cmd    = iss_fire ? sel_ent.alu_cmd : '0;
  assign bus.o_count          = count_q;

  // Incoming uop, with a same-cycle writeback bypassed into a waiting source.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.s0_rob  = bus.i_dsp_src0_rob;
    new_ent.s1_rob  = bus.i_dsp_src1_rob;
    new_ent.s0_rdy  = bus.i_dsp_src0_rdy;
    new_ent.s1_rdy  = bus.i_dsp_src1_rdy;
    new_ent.s0_val  = bus.i_dsp_src0_value;
    new_ent.s1_val  = bus.i_dsp_src1_value;
    new_ent.dst_rob = bus.i_dsp_dst_rob;
    new_ent.imm     = bus.i_dsp_imm;
    new_ent.fid     = bus.i_dsp_fid;
    new_ent.alu_cmd = bus.i_dsp_alu_cmd;
    if (!bus.i_dsp_src0_rdy && bus.i_wb_valid && bus.i_wb_rob == bus.i_dsp_src0_rob) begin
      new_ent.s0_rdy = 1'b1;
      new_ent.s0_val = bus.i_wb_value;
    end
    if (!bus.i_dsp_src1_rdy && bus.i_wb_valid && bus.i_wb_rob == bus.i_dsp_src1_rob) begin
      new_ent.s1_rdy = 1'b1;
      new_ent.s1_val = bus.i_wb_value;
    end
  end

  always_comb begin
    ent_ext              = '0;
    ent_ext[DEPTH-1:0]   = ent_q;
    ent_d                = ent_q;
    count_d              = count_q + 4'(dsp_fire) - 4'(iss_fire);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      // Compaction first, so wakeup lands on the entry's post-shift slot.
      if (iss_fire && k >= 32'(sel)) begin
        ent_d[k] = ent_ext[k+1];
      end
      if (ent_d[k].valid && bus.i_wb_valid) begin
        if (!ent_d[k].s0_rdy && ent_d[k].s0_rob == bus.i_wb_rob) begin
          ent_d[k].s0_rdy = 1'b1;
          ent_d[k].s0_val = bus.i_wb_value;
        end
        if (!ent_d[k].s1_rdy && ent_d[k].s1_rob == bus.i_wb_rob) begin
          ent_d[k].s1_rdy = 1'b1;
          ent_d[k].s1_val = bus.i_wb_value;
        end
      end
      if (dsp_fire && 4'(k) == widx) begin
        ent_d[k] = new_ent;
      end
    end
    if (bus.i_flush) begin
      ent_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_execute_alu_issue.sv
// Self-checking bench for execute_alu_issue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the issue queue.
module tb_execute_alu_issue;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  execute_alu_issue_if bus ();

  execute_alu_issue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          s0r;
    logic [3:0]  s0rob;
    logic [31:0] s0v;
    bit          s1r;
    logic [3:0]  s1rob;
    logic [31:0] s1v;
    logic [3:0]  dst;
    logic [25:0] imm;
    logic [7:0]  fid;
    logic [4:0]  cmd;
  } ment_t;

  // Reference model: entries in age order; the oldest fully-ready one issues.
  ment_t mq[$];

  function automatic int first_ready();
    foreach (mq[i]) if (mq[i].s0r && mq[i].s1r) return i;
    return -1;
  endfunction

  function automatic void model_update();
    int    n;
    int    f;
    ment_t e;
    if (reset || bus.i_flush) begin
      mq.delete();
      return;
    end
    n = mq.size();
    f = first_ready();
    if (f >= 0 && bus.i_iss_ready) mq.delete(f);
    if (bus.i_wb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].s0r && mq[i].s0rob == bus.i_wb_rob) begin
          mq[i].s0r = 1; mq[i].s0v = bus.i_wb_value;
        end
        if (!mq[i].s1r && mq[i].s1rob == bus.i_wb_rob) begin
          mq[i].s1r = 1; mq[i].s1v = bus.i_wb_value;
        end
      end
    end
    if (bus.i_dsp_valid && n < DEPTH) begin
      e.s0r = bus.i_dsp_src0_rdy; e.s0rob = bus.i_dsp_src0_rob; e.s0v = bus.i_dsp_src0_value;
      e.s1r = bus.i_dsp_src1_rdy; e.s1rob = bus.i_dsp_src1_rob; e.s1v = bus.i_dsp_src1_value;
      if (!e.s0r && bus.i_wb_valid && bus.i_wb_rob == e.s0rob) begin
        e.s0r = 1; e.s0v = bus.i_wb_value;
      end
      if (!e.s1r && bus.i_wb_valid && bus.i_wb_rob == e.s1rob) begin
        e.s1r = 1; e.s1v = bus.i_wb_value;
      end
      e.dst = bus.i_dsp_dst_rob; e.imm = bus.i_dsp_imm;
      e.fid = bus.i_dsp_fid;     e.cmd = bus.i_dsp_alu_cmd;
      mq.push_back(e);
    end
  endfunction

  // Advance one clock; the model consumes the inputs the DUT samples at this edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.i_dsp_valid = 0; bus.i_dsp_src0_rdy = 0; bus.i_dsp_src0_rob = 0;
    bus.i_dsp_src0_value = 0; bus.i_dsp_src1_rdy = 0; bus.i_dsp_src1_rob = 0;
    bus.i_dsp_src1_value = 0; bus.i_dsp_dst_rob = 0; bus.i_dsp_imm = 0;
    bus.i_dsp_fid = 0; bus.i_dsp_alu_cmd = 0; bus.i_wb_valid = 0; bus.i_wb_rob = 0;
    bus.i_wb_value = 0; bus.i_flush = 0; bus.i_iss_ready = 1;
  endtask

  task automatic set_dsp(input bit s0r, input logic [3:0] s0rob, input logic [31:0] s0v,
                         input bit s1r, input logic [3:0] s1rob, input logic [31:0] s1v,
                         input logic [3:0] dst);
    bus.i_dsp_valid = 1;
    bus.i_dsp_src0_rdy = s0r; bus.i_dsp_src0_rob = s0rob; bus.i_dsp_src0_value = s0v;
    bus.i_dsp_src1_rdy = s1r; bus.i_dsp_src1_rob = s1rob; bus.i_dsp_src1_value = s1v;
    bus.i_dsp_dst_rob = dst;
  endtask

  task automatic set_wb(input logic [3:0] rob, input logic [31:0] val);
    bus.i_wb_valid = 1; bus.i_wb_rob = rob; bus.i_wb_value = val;
  endtask

  task automatic test_reset();
    reset = 1;
    drive_idle();
    bus.i_dsp_valid = 1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_dsp_ready !== 1'b0 || bus.o_iss_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs got rdy=%0d vld=%0d want 0 0", bus.o_dsp_ready, bus.o_iss_valid);
    end
    tests_run++;
    if (bus.o_iss_src0_value !== 32'd0 || bus.o_iss_dst_rob !== 4'd0 || bus.o_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_data got src0=%0h dst=%0d cnt=%0d want 0", bus.o_iss_src0_value,
               bus.o_iss_dst_rob, bus.o_count);
    end
    tick();
    reset = 0;
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_dsp_ready !== 1'b1 || bus.o_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_release got rdy=%0d cnt=%0d want 1 0", bus.o_dsp_ready, bus.o_count);
    end
  endtask

  task automatic test_single();
    set_dsp(1, 0, 5, 1, 0, 7, 3);
    bus.i_dsp_imm = 26'h155; bus.i_dsp_fid = 8'h42; bus.i_dsp_alu_cmd = 5'd9;
    #1;
    tests_run++;
    if (bus.o_iss_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency got vld=%0d want 0", bus.o_iss_valid);
    end
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_iss_valid !== 1'b1 || bus.o_iss_src0_value !== 32'd5 ||
        bus.o_iss_src1_value !== 32'd7 || bus.o_iss_dst_rob !== 4'd3) begin
      tests_failed++;
      $display("FAIL single_issue got vld=%0d src0=%0d src1=%0d dst=%0d want 1 5 7 3",
               bus.o_iss_valid, bus.o_iss_src0_value, bus.o_iss_src1_value, bus.o_iss_dst_rob);
    end
    tests_run++;
    if (bus.o_iss_imm !== 26'h155 || bus.o_iss_fid !== 8'h42 || bus.o_iss_alu_cmd !== 5'd9 ||
        bus.o_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL single_fields got imm=%0h fid=%0h cmd=%0d cnt=%0d want 155 42 9 1",
               bus.o_iss_imm, bus.o_iss_fid, bus.o_iss_alu_cmd, bus.o_count);
    end
    tick();
    tests_run++;
    if (bus.o_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_drain got cnt=%0d want 0", bus.o_count);
    end
  endtask

  task automatic test_wakeup_order();
    set_dsp(0, 9, 0, 1, 0, 32'h22, 1);
    tick();
    drive_idle();
    set_dsp(1, 0, 32'h33, 1, 0, 32'h44, 2);
    tick();
    drive_idle();
    set_wb(9, 32'h1234);
    #1;
    tests_run++;
    if (bus.o_iss_valid !== 1'b1 || bus.o_iss_dst_rob !== 4'd2 || bus.o_count !== 4'd2) begin
      tests_failed++;
      $display("FAIL wake_young_first got vld=%0d dst=%0d cnt=%0d want 1 2 2",
               bus.o_iss_valid, bus.o_iss_dst_rob, bus.o_count);
    end
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_iss_valid !== 1'b1 || bus.o_iss_dst_rob !== 4'd1 ||
        bus.o_iss_src0_value !== 32'h1234 || bus.o_iss_src1_value !== 32'h22) begin
      tests_failed++;
      $display("FAIL wake_old_next got vld=%0d dst=%0d src0=%0h src1=%0h want 1 1 1234 22",
               bus.o_iss_valid, bus.o_iss_dst_rob, bus.o_iss_src0_value, bus.o_iss_src1_value);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_idle();
      set_dsp(0, 4'(10 + i), 0, 1, 0, 32'(i), 4'(4 + i));
      tick();
    end
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_dsp_ready !== 1'b0 || bus.o_count !== 4'd4 || bus.o_iss_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_state got rdy=%0d cnt=%0d vld=%0d want 0 4 0",
               bus.o_dsp_ready, bus.o_count, bus.o_iss_valid);
    end
    set_dsp(1, 0, 1, 1, 0, 1, 15);
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_count !== 4'd4 || bus.o_iss_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ignore got cnt=%0d vld=%0d want 4 0", bus.o_count, bus.o_iss_valid);
    end
    // Wake youngest first while stalled so the release shows pure age order.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      drive_idle();
      bus.i_iss_ready = 0;
      set_wb(4'(10 + i), 32'(100 + i));
      tick();
    end
    drive_idle();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      tests_run++;
      if (bus.o_iss_valid !== 1'b1 || bus.o_iss_dst_rob !== 4'(4 + i) ||
          bus.o_iss_src0_value !== 32'(100 + i)) begin
        tests_failed++;
        $display("FAIL full_order[%0d] got vld=%0d dst=%0d src0=%0d want 1 %0d %0d", i,
                 bus.o_iss_valid, bus.o_iss_dst_rob, bus.o_iss_src0_value, 4 + i, 100 + i);
      end
      tick();
    end
    tests_run++;
    if (bus.o_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL full_drain got cnt=%0d want 0", bus.o_count);
    end
  endtask

  task automatic test_bypass();
    set_dsp(1, 0, 32'h11, 0, 6, 0, 5);
    set_wb(6, 32'hAA);
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_iss_valid !== 1'b1 || bus.o_iss_src1_value !== 32'hAA ||
        bus.o_iss_src0_value !== 32'h11) begin
      tests_failed++;
      $display("FAIL bypass got vld=%0d src0=%0h src1=%0h want 1 11 aa",
               bus.o_iss_valid, bus.o_iss_src0_value, bus.o_iss_src1_value);
    end
    tick();
  endtask

  task automatic test_stall();
    drive_idle();
    bus.i_iss_ready = 0;
    set_dsp(1, 0, 1, 1, 0, 2, 7);
    tick();
    set_dsp(1, 0, 3, 1, 0, 4, 8);
    tick();
    drive_idle();
    bus.i_iss_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.o_iss_valid !== 1'b0 || bus.o_count !== 4'd2) begin
        tests_failed++;
        $display("FAIL stall[%0d] got vld=%0d cnt=%0d want 0 2", i, bus.o_iss_valid, bus.o_count);
      end
      tick();
    end
    bus.i_iss_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (bus.o_iss_valid !== 1'b1 || bus.o_iss_dst_rob !== 4'(7 + i)) begin
        tests_failed++;
        $display("FAIL stall_release[%0d] got vld=%0d dst=%0d want 1 %0d", i,
                 bus.o_iss_valid, bus.o_iss_dst_rob, 7 + i);
      end
      tick();
    end
  endtask

  task automatic test_flush_reset();
    drive_idle();
    set_dsp(1, 0, 1, 1, 0, 1, 1);
    tick();
    set_dsp(0, 2, 0, 1, 0, 1, 2);
    tick();
    set_dsp(1, 0, 5, 1, 0, 5, 3);
    set_wb(2, 32'h77);
    bus.i_flush = 1;
    #1;
    tests_run++;
    if (bus.o_iss_valid !== 1'b0 || bus.o_iss_dst_rob !== 4'd0) begin
      tests_failed++;
      $display("FAIL flush_noissue got vld=%0d dst=%0d want 0 0", bus.o_iss_valid, bus.o_iss_dst_rob);
    end
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.o_count !== 4'd0 || bus.o_iss_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_empty got cnt=%0d vld=%0d want 0 0", bus.o_count, bus.o_iss_valid);
    end
    bus.i_iss_ready = 0;
    set_dsp(1, 0, 9, 1, 0, 9, 4);
    tick();
    tick();
    drive_idle();
    reset = 1;
    #1;
    tests_run++;
    if (bus.o_dsp_ready !== 1'b0 || bus.o_iss_valid !== 1'b0 || bus.o_iss_src0_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset got rdy=%0d vld=%0d src0=%0h want 0 0 0",
               bus.o_dsp_ready, bus.o_iss_valid, bus.o_iss_src0_value);
    end
    tick();
    reset = 0;
    #1;
    tests_run++;
    if (bus.o_count !== 4'd0 || bus.o_dsp_ready !== 1'b1 || bus.o_iss_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_after got cnt=%0d rdy=%0d vld=%0d want 0 1 0",
               bus.o_count, bus.o_dsp_ready, bus.o_iss_valid);
    end
  endtask

  task automatic test_random();
    int          f;
    logic        ev;
    logic [106:0] edata;
    logic [106:0] adata;
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      reset = ($urandom_range(0, 79) == 0);
      bus.i_flush = ($urandom_range(0, 39) == 0);
      bus.i_iss_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) begin
        set_dsp($urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), $urandom,
                4'($urandom));
        bus.i_dsp_imm = 26'($urandom); bus.i_dsp_fid = 8'($urandom);
        bus.i_dsp_alu_cmd = 5'($urandom);
      end
      if ($urandom_range(0, 1) == 1) set_wb(4'($urandom_range(0, 3)), $urandom);
      #1;
      f  = first_ready();
      ev = (f >= 0) && bus.i_iss_ready && !bus.i_flush && !reset;
      edata = ev ? {mq[f].s0v, mq[f].s1v, mq[f].dst, mq[f].imm, mq[f].fid, mq[f].cmd} : '0;
      adata = {bus.o_iss_src0_value, bus.o_iss_src1_value, bus.o_iss_dst_rob, bus.o_iss_imm,
               bus.o_iss_fid, bus.o_iss_alu_cmd};
      tests_run++;
      if (bus.o_iss_valid !== ev) begin
        tests_failed++;
        $display("FAIL rand_valid cyc=%0d got %0d want %0d", c, bus.o_iss_valid, ev);
      end
      tests_run++;
      if (adata !== edata) begin
        tests_failed++;
        $display("FAIL rand_data cyc=%0d got %h want %h", c, adata, edata);
      end
      tests_run++;
      if (bus.o_count !== 4'(mq.size()) || bus.o_dsp_ready !== (mq.size() < DEPTH && !reset)) begin
        tests_failed++;
        $display("FAIL rand_occ cyc=%0d got cnt=%0d rdy=%0d want cnt=%0d", c, bus.o_count,
                 bus.o_dsp_ready, mq.size());
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_wakeup_order();
    test_full();
    test_bypass();
    test_stall();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
